uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter: pops words from a show-ahead TX FIFO and serialises them LSB-first.

---
 rtl/uart_tx_cfg.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame configuration latch, parity, 1/2 stop bits
// and line-break generation. Pops words from a show-ahead FIFO and shifts
// them out LSB-first with back-to-back framing.
module uart_tx_cfg #(
    parameter int unsigned DIV_W    = 24,
    parameter logic        IDLE_LVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_n,
    input  logic [DIV_W-1:0] ckdiv,
    input  logic [3:0]       dlen,
    input  logic [2:0]       parity,
    input  logic             stop2b,
    input  logic             brk,
    output logic             txbusy,
    output logic             tx_done,
    output logic             tf_read,
    input  logic [8:0]       tf_rbyte,
    input  logic             tf_empty,
    output logic             uart_txd
);

    localparam int unsigned DW = 9;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] ckdiv_q, ckdiv_d;
    logic [DW-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    cnt_init_q, cnt_init_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             stop2b_q, stop2b_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             brk_frame_q, brk_frame_d;
    logic             txd_d;
    logic             tf_read_d;
    logic             tx_done_d;

    logic             soft_rst;
    logic             tick;
    logic [CW-1:0]    dlen_eff;
    logic [DW-1:0]    data_mask;
    logic             data_par;
    logic             par_en_c;
    logic             par_bit_c;
    logic             do_pop;
    logic             do_brk;

    assign soft_rst = rst | ~clr_n;
    assign tick     = (div_q == '0);
    assign txbusy   = ~((state_q == S_IDLE) & tf_empty & ~brk);

    // Clamp the requested data length into the supported 5..9 range
    always_comb begin
        dlen_eff = dlen;
        if (dlen < CW'(5)) begin
            dlen_eff = CW'(5);
        end else if (dlen > CW'(9)) begin
            dlen_eff = CW'(9);
        end
    end

    // Parity of the head word over the active data bits only
    always_comb begin
        data_mask = DW'((10'd1 << dlen_eff) - 10'd1);
        data_par  = ^(tf_rbyte & data_mask);
        par_en_c  = (parity >= 3'd1) && (parity <= 3'd4);
        case (parity)
            3'd1:    par_bit_c = ~data_par;
            3'd2:    par_bit_c = data_par;
            3'd3:    par_bit_c = 1'b1;
            default: par_bit_c = 1'b0;
        endcase
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        ckdiv_d     = ckdiv_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_init_d  = cnt_init_q;
        stop_cnt_d  = stop_cnt_q;
        stop2b_d    = stop2b_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        brk_frame_d = brk_frame_q;
        txd_d       = uart_txd;
        tf_read_d   = 1'b0;
        tx_done_d   = 1'b0;
        do_pop      = 1'b0;
        do_brk      = 1'b0;

        // bit-period divider runs whenever a frame or break is in progress
        if (state_q != S_IDLE) begin
            div_d = tick ? ckdiv_q : (div_q - DIV_W'(1));
        end

        case (state_q)
            S_IDLE: begin
                if (brk) begin
                    do_brk = 1'b1;
                end else if (!tf_empty) begin
                    do_pop = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    txd_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = cnt_init_q;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q != '0) begin
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q - CW'(1);
                    end else if (par_en_q) begin
                        state_d = S_PAR;
                        txd_d   = par_bit_q;
                    end else begin
                        state_d    = S_STOP;
                        txd_d      = IDLE_LVL;
                        stop_cnt_d = stop2b_q;
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    state_d    = S_STOP;
                    txd_d      = IDLE_LVL;
                    stop_cnt_d = stop2b_q;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt_q) begin
                        stop_cnt_d = 1'b0;
                    end else begin
                        tx_done_d = ~brk_frame_q;
                        if (brk) begin
                            do_brk = 1'b1;
                        end else if (!tf_empty) begin
                            do_pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            div_d   = '0;
                        end
                    end
                end
            end
            S_BREAK: begin
                txd_d = ~IDLE_LVL;
                if (tick && !brk) begin
                    state_d    = S_STOP;
                    txd_d      = IDLE_LVL;
                    stop_cnt_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = IDLE_LVL;
                div_d   = '0;
            end
        endcase

        // frame start: pop the head word and latch this frame's configuration
        if (do_pop) begin
            state_d     = S_START;
            txd_d       = ~IDLE_LVL;
            shreg_d     = tf_rbyte;
            tf_read_d   = 1'b1;
            ckdiv_d     = ckdiv;
            div_d       = ckdiv;
            cnt_init_d  = dlen_eff - CW'(1);
            stop2b_d    = stop2b;
            par_en_d    = par_en_c;
            par_bit_d   = par_bit_c;
            brk_frame_d = 1'b0;
        end

        // break start: hold the line at the active level, no FIFO access
        if (do_brk) begin
            state_d     = S_BREAK;
            txd_d       = ~IDLE_LVL;
            ckdiv_d     = ckdiv;
            div_d       = ckdiv;
            brk_frame_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset / soft clear
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            ckdiv_q     <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            cnt_init_q  <= '0;
            stop_cnt_q  <= 1'b0;
            stop2b_q    <= 1'b0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            brk_frame_q <= 1'b0;
            uart_txd    <= IDLE_LVL;
            tf_read     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            ckdiv_q     <= ckdiv_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_init_q  <= cnt_init_d;
            stop_cnt_q  <= stop_cnt_d;
            stop2b_q    <= stop2b_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            brk_frame_q <= brk_frame_d;
            uart_txd    <= txd_d;
            tf_read     <= tf_read_d;
            tx_done     <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: table of single-frame vectors plus hand-written
// sequences for back-to-back frames, line break and mid-frame reset/clear.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_n;
    logic [23:0] ckdiv;
    logic [3:0]  dlen;
    logic [2:0]  parity;
    logic        stop2b;
    logic        brk;
    logic        txbusy;
    logic        tx_done;
    logic        tf_read;
    logic [8:0]  tf_rbyte;
    logic        tf_empty;
    logic        uart_txd;

    int n_vec = 0;
    int n_bad = 0;

    uart_tx_cfg #(.DIV_W(24), .IDLE_LVL(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_n    (clr_n),
        .ckdiv    (ckdiv),
        .dlen     (dlen),
        .parity   (parity),
        .stop2b   (stop2b),
        .brk      (brk),
        .txbusy   (txbusy),
        .tx_done  (tx_done),
        .tf_read  (tf_read),
        .tf_rbyte (tf_rbyte),
        .tf_empty (tf_empty),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: head advances on the edge that sees tf_read
    logic [8:0] fmem [16];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic       fifo_init;

    assign tf_empty = (wr_ptr == rd_ptr);
    assign tf_rbyte = fmem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_init) rd_ptr <= 4'd0;
        else if (tf_read) rd_ptr <= rd_ptr + 4'd1;
    end

    typedef struct {
        logic [3:0]  dlen;
        logic [2:0]  par;
        logic        stop2b;
        int          ck;
        logic [8:0]  word;
        int          nbits;
        logic [12:0] bits;   // bit i = level of the i-th transmitted bit (start first)
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [8:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (uart_txd !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, int'(uart_txd), 0);
    endtask

    // Check one complete frame cycle by cycle from the start bit onwards
    task automatic run_frame(input string tag, input int ck, input int nbits,
                             input logic [12:0] bits);
        int err, rd, early;
        wait_start(tag);
        rd = 0;
        early = 0;
        for (int i = 0; i < nbits; i++) begin
            err = 0;
            for (int j = 0; j <= ck; j++) begin
                if (uart_txd !== bits[i]) err++;
                if (tx_done !== 1'b0) early++;
                if (tf_read === 1'b1) rd++;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, i), err, 0);
        end
        chk({tag, "_tx_done"}, int'(tx_done), 1);
        chk({tag, "_stop_level"}, int'(uart_txd), 1);
        chk({tag, "_no_early_done"}, early, 0);
        chk({tag, "_tf_read_count"}, rd, 1);
    endtask

    initial begin
        logic [9:0] f1, f2;
        logic       e;
        int err, rd, rd_brk, busy_err, done_err;

        vecs[0] = '{4'd8,  3'd0, 1'b0, 3, 9'h055, 10, 13'h02AA};
        vecs[1] = '{4'd9,  3'd2, 1'b0, 1, 9'h1A5, 12, 13'h0F4A};
        vecs[2] = '{4'd7,  3'd1, 1'b1, 2, 9'h041, 11, 13'h0782};
        vecs[3] = '{4'd5,  3'd2, 1'b0, 1, 9'h0E1,  8, 13'h00C2};
        vecs[4] = '{4'd3,  3'd4, 1'b0, 1, 9'h016,  8, 13'h00AC};
        vecs[5] = '{4'd15, 3'd6, 1'b1, 1, 9'h100, 12, 13'h0E00};
        vecs[6] = '{4'd8,  3'd1, 1'b0, 1, 9'h000, 11, 13'h0600};

        rst = 1'b1; clr_n = 1'b1; brk = 1'b0;
        ckdiv = 24'd3; dlen = 4'd8; parity = 3'd0; stop2b = 1'b0;
        wr_ptr = 4'd0; fifo_init = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_txd", int'(uart_txd), 1);
        chk("reset_tf_read", int'(tf_read), 0);
        chk("reset_tx_done", int'(tx_done), 0);
        chk("reset_txbusy", int'(txbusy), 0);
        rst = 1'b0; fifo_init = 1'b0;
        @(negedge clk);

        // single-frame vectors
        for (int k = 0; k < 7; k++) begin
            dlen   = vecs[k].dlen;
            parity = vecs[k].par;
            stop2b = vecs[k].stop2b;
            ckdiv  = 24'(vecs[k].ck);
            push(vecs[k].word);
            run_frame($sformatf("vec%0d", k), vecs[k].ck, vecs[k].nbits, vecs[k].bits);
        end
        @(negedge clk);
        chk("idle_txbusy", int'(txbusy), 0);

        // back-to-back frames; mid-frame config change must not affect frame 1
        ckdiv = 24'd1; dlen = 4'd8; parity = 3'd0; stop2b = 1'b0;
        push(9'h00F);
        push(9'h0F0);
        wait_start("b2b");
        f1 = {1'b1, 8'h0F, 1'b0};
        f2 = {1'b1, 8'hF0, 1'b0};
        err = 0; rd = 0; busy_err = 0; done_err = 0;
        for (int c = 0; c < 40; c++) begin
            e = (c < 20) ? f1[c / 2] : f2[(c - 20) / 2];
            if (uart_txd !== e) err++;
            if (txbusy !== 1'b1) busy_err++;
            if (tf_read === 1'b1) rd++;
            if (tx_done !== (c == 20)) done_err++;
            if (c == 3) begin dlen = 4'd5; parity = 3'd2; end
            if (c == 10) begin dlen = 4'd8; parity = 3'd0; end
            @(negedge clk);
        end
        chk("b2b_wave", err, 0);
        chk("b2b_txbusy", busy_err, 0);
        chk("b2b_tf_read_count", rd, 2);
        chk("b2b_done_timing", done_err, 0);
        chk("b2b_final_done", int'(tx_done), 1);
        chk("b2b_final_idle", int'(txbusy), 0);

        // line break with a word queued: no pop until the break's stop bit ends
        ckdiv = 24'd3;
        brk = 1'b1;
        push(9'h055);
        @(negedge clk);
        f1 = {1'b1, 8'h55, 1'b0};
        err = 0; rd = 0; rd_brk = 0; done_err = 0;
        for (int c = 0; c < 76; c++) begin
            if (c < 32) e = 1'b0;
            else if (c < 36) e = 1'b1;
            else e = f1[(c - 36) / 4];
            if (uart_txd !== e) err++;
            if (tf_read === 1'b1) begin
                rd++;
                if (c < 36) rd_brk++;
            end
            if (tx_done !== 1'b0) done_err++;
            if (c == 29) brk = 1'b0;
            @(negedge clk);
        end
        chk("brk_wave", err, 0);
        chk("brk_no_pop_during_break", rd_brk, 0);
        chk("brk_tf_read_count", rd, 1);
        chk("brk_no_done_after_break", done_err, 0);
        chk("brk_frame_done", int'(tx_done), 1);

        // synchronous reset during data bit 3, then a clean restart
        push(9'h055);
        wait_start("rst");
        err = 0;
        for (int c = 0; c < 18; c++) begin
            if (uart_txd !== f1[c / 4]) err++;
            if (c == 17) rst = 1'b1;
            @(negedge clk);
        end
        chk("rst_pre_wave", err, 0);
        chk("rst_txd", int'(uart_txd), 1);
        chk("rst_txbusy", int'(txbusy), 0);
        chk("rst_tf_read", int'(tf_read), 0);
        chk("rst_tx_done", int'(tx_done), 0);
        rst = 1'b0;
        err = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) err++;
        end
        chk("rst_stays_idle", err, 0);
        push(9'h00F);
        run_frame("rst_restart", 3, 10, 13'h021E);

        // soft clear during a start bit drops the frame
        push(9'h0AA);
        wait_start("clr");
        clr_n = 1'b0;
        @(negedge clk);
        chk("clr_txd", int'(uart_txd), 1);
        chk("clr_tf_read", int'(tf_read), 0);
        chk("clr_txbusy", int'(txbusy), 0);
        clr_n = 1'b1;
        err = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) err++;
        end
        chk("clr_stays_idle", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
